// File: rtl/irq_controller.sv
// irq_controller: maskable edge/level interrupt controller, lowest channel index wins.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser on every irq_in bit.
module irq_controller #(
  parameter int NUM_CH  = 4,
  parameter int NUM_W   = 32,
  parameter int HOLDOFF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              INTin,
  output logic [NUM_W-1:0]  INTnum,
  input  logic              int_ack,
  output logic [1:0]        state_dbg
);

  // Handshake: INTin rises with INTnum valid and both hold until the cycle
  // int_ack=1 is sampled in REQ; INTin drops on the following cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [NUM_CH-1:0] irq_s, irq_prev;
  logic [NUM_CH-1:0] mask_q, edge_q, pend_q, pend_n;
  logic [NUM_CH-1:0] rise, clr;
  logic [31:0]       base_q;
  logic [4:0]        ch_q, win_ch;
  logic [3:0]        hold_q, hold_n;
  logic [NUM_W-1:0]  num_q;
  logic              win_any, grant, ack_hit;

`ifdef IRQ_SYNC_EN
  logic [NUM_CH-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  // Lowest eligible index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    win_any = 1'b0;
    win_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i] && mask_q[i]) begin
        win_any = 1'b1;
        win_ch  = 5'(i);
      end
    end
  end

  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    grant   = 1'b0;
    ack_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_n = REQ;
          grant   = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_hit = 1'b1;
          if (HOLDOFF == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLD;
            hold_n  = 4'(HOLDOFF - 1);
          end
        end
      end
      HOLD: begin
        if (hold_q == 4'd0) state_n = IDLE;
        else                hold_n  = hold_q - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Edge channels: a new rising edge beats any clear in the same cycle.
  // Level channels simply mirror the sampled input.
  always_comb begin
    rise = irq_s & ~irq_prev;
    clr  = '0;
    if (cfg_we && cfg_addr == 2'd2) clr = cfg_wdata[NUM_CH-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (ack_hit && ch_q == 5'(i)) clr[i] = 1'b1;
    end
    pend_n = (edge_q & (rise | (pend_q & ~clr))) | (~edge_q & irq_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ch_q    <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      if (grant) begin
        ch_q  <= win_ch;
        num_q <= NUM_W'(base_q) + NUM_W'(win_ch);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      edge_q   <= '1;
      pend_q   <= '0;
      base_q   <= '0;
      irq_prev <= '0;
    end else begin
      irq_prev <= irq_s;
      pend_q   <= pend_n;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    mask_q <= cfg_wdata[NUM_CH-1:0];
          2'd1:    edge_q <= cfg_wdata[NUM_CH-1:0];
          2'd3:    base_q <= cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = 32'(mask_q);
      2'd1:    cfg_rdata = 32'(edge_q);
      2'd2:    cfg_rdata = 32'(pend_q);
      default: cfg_rdata = base_q;
    endcase
  end

  assign INTin     = (state_q == REQ);
  assign INTnum    = num_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized traffic against a
// behavioural model of the interrupt controller (NUM_CH=4, HOLDOFF=2).
module tb_irq_controller;
  localparam int NUM_CH  = 4;
  localparam int NUM_W   = 32;
  localparam int HOLDOFF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        INTin;
  logic [31:0] INTnum;
  logic        int_ack;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: registers plus "request live" flag and quiet-cycle countdown.
  logic [3:0]  m_mask, m_edge, m_pend, m_prev;
  logic [31:0] m_base, m_num;
  logic        m_int;
  int          m_ch, m_quiet;
  logic        seen_int;
  int          n;

  irq_controller #(
    .NUM_CH (NUM_CH),
    .NUM_W  (NUM_W),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .INTin    (INTin),
    .INTnum   (INTnum),
    .int_ack  (int_ack),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mask  = 4'h0;
    m_edge  = 4'hF;
    m_pend  = 4'h0;
    m_prev  = 4'h0;
    m_base  = 32'h0;
    m_num   = 32'h0;
    m_int   = 1'b0;
    m_ch    = 0;
    m_quiet = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_mask};
      2'd1:    return {28'b0, m_edge};
      2'd2:    return {28'b0, m_pend};
      default: return m_base;
    endcase
  endfunction

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic model_step();
    logic [3:0] elig, clrv, nxt;
    elig = m_pend & m_mask;
    clrv = 4'h0;
    if (cfg_we && cfg_addr == 2'd2) clrv = cfg_wdata[3:0];
    if (m_int && int_ack) clrv[m_ch] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_edge[i]) nxt[i] = (irq_in[i] && !m_prev[i]) ? 1'b1 : (m_pend[i] && !clrv[i]);
      else           nxt[i] = irq_in[i];
    end
    if (m_int) begin
      if (int_ack) begin
        m_int   = 1'b0;
        m_quiet = HOLDOFF;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (elig != 4'h0) begin
      m_ch = 0;
      while (!elig[m_ch]) m_ch++;
      m_int = 1'b1;
      m_num = m_base + 32'(m_ch);
      exp_q.push_back(m_num);
    end
    m_pend = nxt;
    m_prev = irq_in;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    m_mask = cfg_wdata[3:0];
        2'd1:    m_edge = cfg_wdata[3:0];
        2'd3:    m_base = cfg_wdata;
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    check("int_in", 32'(INTin), 32'(m_int));
    if (m_int) check("int_num", INTnum, m_num);
    check("rdata", cfg_rdata, model_rd(cfg_addr));
    if (INTin && !seen_int) begin
      check("sb_grant_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_vector", INTnum, exp_q.pop_front());
    end
    seen_int = INTin;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic wait_int(input int max, output int cnt);
    cnt = 0;
    while (!INTin && cnt < max) begin
      tick();
      cnt++;
    end
    check("wait_int_timeout", 32'(INTin), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_intin"}, 32'(INTin), 32'd0);
    check({tag, "_intnum"}, INTnum, 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      check({tag, "_reg"}, cfg_rdata, (a == 1) ? 32'hF : 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; int_ack = 1'b0; seen_int = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single edge pulse on ch2
    cfg_write(2'd0, 32'hF);
    cfg_write(2'd1, 32'hF);
    cfg_write(2'd3, 32'h10);
    cfg_addr = 2'd2;
    irq_in = 4'b0100; tick();
    check("t23_pending_set", cfg_rdata, 32'h4);
    check("t23_int_not_yet", 32'(INTin), 32'd0);
    irq_in = 4'b0000; tick();
    check("t23_int", 32'(INTin), 32'd1);
    check("t23_num", INTnum, 32'h12);
    tick();
    ack();
    check("t23_int_drop", 32'(INTin), 32'd0);
    check("t23_pend_clr", cfg_rdata, 32'h0);
    repeat (4) tick();

    // Two simultaneous edges: ch1 then ch3 after holdoff
    irq_in = 4'b1010; tick();
    irq_in = 4'b0000; tick();
    check("t24_first", INTnum, 32'h11);
    ack();
    wait_int(6, n);
    check("t24_gap", 32'(n), 32'd3);
    check("t24_second", INTnum, 32'h13);
    ack();
    repeat (4) tick();

    // Level channel held high re-requests after each holdoff
    cfg_write(2'd1, 32'h0);
    irq_in = 4'b0001;
    wait_int(4, n);
    check("t25_num", INTnum, 32'h10);
    cfg_write(2'd2, 32'h1);
    check("t25_w1c_level", cfg_rdata, 32'h1);
    ack();
    wait_int(6, n);
    check("t25_reassert1", 32'(n), 32'd3);
    ack();
    wait_int(6, n);
    check("t25_reassert2", 32'(n), 32'd3);
    ack();
    tick();
    irq_in = 4'b0000;
    repeat (6) tick();
    check("t25_quiet", 32'(INTin), 32'd0);
    cfg_write(2'd1, 32'hF);
    tick();

    // Mask and base changes during REQ; edge in the ack cycle survives
    irq_in = 4'b0100; tick();
    irq_in = 4'b0000; tick();
    check("t26_int", 32'(INTin), 32'd1);
    cfg_write(2'd0, 32'h0);
    tick();
    check("t26_hold_int", 32'(INTin), 32'd1);
    check("t26_hold_num", INTnum, 32'h12);
    cfg_write(2'd3, 32'h40);
    check("t26_base_num", INTnum, 32'h12);
    irq_in = 4'b0100; int_ack = 1'b1; tick();
    irq_in = 4'b0000; int_ack = 1'b0;
    cfg_addr = 2'd2;
    #1;
    check("t26_pend_kept", cfg_rdata, 32'h4);
    check("t26_int_drop", 32'(INTin), 32'd0);
    repeat (5) tick();
    check("t26_masked", 32'(INTin), 32'd0);
    cfg_write(2'd0, 32'hF);
    wait_int(4, n);
    check("t26_reenable", INTnum, 32'h42);
    ack();
    repeat (4) tick();

    // Vector wrap and reset abandoning a live request
    cfg_write(2'd3, 32'hFFFF_FFFF);
    irq_in = 4'b0010; tick();
    irq_in = 4'b0000; tick();
    check("t27_int", 32'(INTin), 32'd1);
    check("t27_wrap", INTnum, 32'h0);
    #2 rst = 1'b1;
    #1 check_reset_values("midreq");
    model_reset();
    exp_q.delete();
    seen_int = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t27_after_rst", 32'(INTin), 32'd0);

    // Randomized traffic
    cfg_write(2'd0, 32'hF);
    cfg_write(2'd1, 32'h5);
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) irq_in = 4'($urandom_range(0, 15));
      int_ack   = ($urandom_range(0, 3) == 0);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom();
      tick();
    end
    cfg_we = 1'b0; int_ack = 1'b0; irq_in = '0;
    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_CH, default 4: number of interrupt channels, legal range 1..32.
REQ-002 Parameter NUM_W, default 32: width of the vector number output.
REQ-003 Parameter HOLDOFF, default 2: idle cycles enforced after each acknowledge, legal range 0..15.
REQ-004 The module SHALL expose these ports, one clock, with reset asynchronous and active-high:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- irq_in  input  NUM_CH  raw peripheral requests; bit i is channel i.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  2  register select.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  read data, combinational from cfg_addr.
- INTin  output  1  interrupt request to CPU.
- INTnum  output  NUM_W  vector number, valid while INTin=1.
- int_ack  input  1  CPU acknowledge, single-cycle pulse.

Function
REQ-005 Register map SHALL be: 0 MASK (1=enabled); 1 EDGE (1=rising-edge, 0=level); 2 PENDING (read; write-1-to-clear); 3 BASE (32-bit vector base). Bits [31:NUM_CH] of MASK, EDGE and PENDING SHALL read 0 and ignore writes.
REQ-006 Edge channel: pending bit SHALL set on the cycle irq_in(i)=1 while the previous-cycle sample was 0.
REQ-007 Level channel: pending bit SHALL equal the sampled irq_in(i) each cycle, and W1C SHALL have no effect on it.
REQ-008 If an edge set and a W1C or ack-clear hit the same bit in the same cycle, the set SHALL win.
REQ-009 Eligible set = PENDING AND MASK; the lowest index SHALL have highest priority.
REQ-010 FSM states SHALL be IDLE, REQ and HOLD.
REQ-011 IDLE->REQ on the first edge where the eligible set is non-zero. That edge SHALL latch the winning channel and set INTin=1 with INTnum=(BASE+ch) mod 2^NUM_W. Latency from the pending bit setting to INTin SHALL be 1 cycle.
REQ-012 In REQ, INTin and INTnum SHALL hold stable until int_ack, even if MASK, BASE or the pending bit change.
REQ-013 REQ with int_ack=1: INTin SHALL drop the next cycle, and an edge channel's served pending bit SHALL be cleared (subject to REQ-008).
REQ-014 After an ack the FSM SHALL go to HOLD for HOLDOFF cycles, then IDLE. With HOLDOFF=0 it SHALL go directly to IDLE.
REQ-015 int_ack in IDLE or HOLD SHALL be ignored.
REQ-016 A level channel still high after ack SHALL re-request after holdoff; no request SHALL be lost while the FSM is busy.
REQ-017 MASK=0 on a pending channel SHALL keep it pending but not eligible; re-enabling it SHALL make it eligible again.
REQ-018 A simultaneous cfg_we and FSM update SHALL apply both; the write takes effect for arbitration on the next cycle.

Reset
REQ-019 While rst=1, asynchronously: MASK=0, EDGE=all 1, PENDING=0, BASE=0, edge-detect history=0, FSM=IDLE, INTin=0, INTnum=0.
REQ-020 Reset asserted mid-REQ or mid-HOLD SHALL abandon the service; no ack SHALL be required afterwards.

Configuration
REQ-021 With macro IRQ_SYNC_EN defined, each irq_in bit SHALL pass through a 2-flop synchroniser (reset to 0) before edge or level logic, adding 2 cycles of latency.
REQ-022 Without IRQ_SYNC_EN, irq_in SHALL be treated as synchronous to clk and sampled directly.

Verification (IRQ_SYNC_EN undefined, NUM_CH=4, HOLDOFF=2)
REQ-023 MASK=0xF, EDGE=0xF, BASE=0x10; pulse irq_in=0b0100 -> INTin=1 with INTnum=0x12 one cycle after pending sets; int_ack -> INTin=0 next cycle, PENDING=0.
REQ-024 irq_in 0b1010 rising together -> INTnum=BASE+1 first; after ack plus 2 hold cycles, INTnum=BASE+3.
REQ-025 EDGE=0, irq_in(0) held high; ack twice -> INTin re-asserts 3 cycles after each ack. Lowering irq_in(0) while in HOLD -> no further request.
REQ-026 In REQ for ch2, write MASK=0 -> INTin/INTnum unchanged until ack. A new edge on ch2 in the ack cycle -> PENDING(2)=1 afterwards.
REQ-027 BASE=0xFFFFFFFF, ch1 fires -> INTnum=0x00000000 (wrap). rst pulsed during REQ -> INTin=0 and all registers at reset values immediately.
